// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: fixed-frequency fan PWM generator with kick-start from
// standstill and a slew-limited duty ramp. The duty command, the applied duty
// and the state change only at PWM period ends, so pwm_out never glitches.
//
// Optional feature (macro FAN_STALL_DET_EN): tach-based stall detection. The
// tach input is synchronised and its rising edges are watched while running.
// If no edge arrives for STALL_PERIODS periods, the fan is kicked again and
// the sticky fan_stall flag is raised. Without the macro, fan_tach is ignored
// and fan_stall is tied to 0.
//
// Ports:
//   sys_clk    in   1  system clock
//   sys_rst    in   1  synchronous, active-high reset
//   duty_in    in   7  commanded duty % (values above 100 clamp to 100)
//   fan_tach   in   1  fan tachometer, asynchronous
//   pwm_out    out  1  registered PWM drive to the fan
//   duty_eff   out  7  duty % currently applied
//   fan_state  out  2  00 OFF, 01 KICK, 10 RUN
//   fan_stall  out  1  sticky stall flag
module fan_pwm_gen #(
  parameter int unsigned PWM_PERIOD    = 2000,
  parameter int unsigned KICK_PERIODS  = 2500,
  parameter int unsigned RAMP_PERIODS  = 4,
  parameter int unsigned STALL_PERIODS = 25000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [6:0] duty_in,
  input  logic       fan_tach,
  output logic       pwm_out,
  output logic [6:0] duty_eff,
  output logic [1:0] fan_state,
  output logic       fan_stall
);

  localparam int unsigned CW   = $clog2(PWM_PERIOD);
  localparam int unsigned TW   = $clog2(PWM_PERIOD + 1);
  localparam int unsigned STEP = PWM_PERIOD / 100;
  localparam int unsigned KW   = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam int unsigned RW   = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  localparam logic [6:0]    DUTY_MAX = 7'd100;
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);

  localparam logic [1:0] ST_OFF  = 2'b00;
  localparam logic [1:0] ST_KICK = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;

  logic [CW-1:0] cnt;
  logic          pe_c;
  logic [6:0]    tgt_c;
  logic [TW-1:0] thr_c;

  logic [1:0]    state, state_n;
  logic [6:0]    duty_n;
  logic [KW-1:0] kick_cnt, kick_n;
  logic [RW-1:0] ramp_cnt, ramp_n;

  assign pe_c  = (cnt == CNT_LAST);
  assign tgt_c = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
  // Constant multiply: duty % times clocks per percent
  assign thr_c = TW'({25'd0, duty_eff} * STEP);

  assign fan_state = state;

`ifdef FAN_STALL_DET_EN
  localparam int unsigned SW = (STALL_PERIODS > 1) ? $clog2(STALL_PERIODS) : 1;

  logic          tach_s1, tach_s2, tach_d;
  logic          tach_edge_c;
  logic [SW-1:0] stall_cnt, stall_cnt_n;
  logic          stall_q, stall_n;

  // Two-flop synchroniser plus a delay flop for rising-edge detection
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tach_s1 <= 1'b0;
      tach_s2 <= 1'b0;
      tach_d  <= 1'b0;
    end else begin
      tach_s1 <= fan_tach;
      tach_s2 <= tach_s1;
      tach_d  <= tach_s2;
    end
  end

  assign tach_edge_c = tach_s2 & ~tach_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_n;
      stall_q   <= stall_n;
    end
  end

  assign fan_stall = stall_q;
`else
  logic unused_tach;
  assign unused_tach = fan_tach | (STALL_PERIODS == 0);
  assign fan_stall   = 1'b0;
`endif

  // Free-running period counter
  always_ff @(posedge sys_clk) begin
    if (sys_rst || pe_c) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end

  // PWM output, one cycle behind cnt
  always_ff @(posedge sys_clk) begin
    if (sys_rst) pwm_out <= 1'b0;
    else         pwm_out <= (TW'(cnt) < thr_c);
  end

  // State and applied-duty registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_OFF;
      duty_eff <= 7'd0;
      kick_cnt <= '0;
      ramp_cnt <= '0;
    end else begin
      state    <= state_n;
      duty_eff <= duty_n;
      kick_cnt <= kick_n;
      ramp_cnt <= ramp_n;
    end
  end

  // Next-state logic; everything except the tach path moves only at period end
  always_comb begin
    state_n = state;
    duty_n  = duty_eff;
    kick_n  = kick_cnt;
    ramp_n  = ramp_cnt;
`ifdef FAN_STALL_DET_EN
    stall_cnt_n = stall_cnt;
    stall_n     = stall_q;
    if (tach_edge_c) begin
      stall_cnt_n = '0;
      stall_n     = 1'b0;
    end
`endif
    if (pe_c) begin
      case (state)
        ST_OFF: begin
          duty_n = 7'd0;
          if (tgt_c != 7'd0) begin
            state_n = ST_KICK;
            duty_n  = DUTY_MAX;
            kick_n  = '0;
          end
        end
        ST_KICK: begin
          duty_n = DUTY_MAX;
          kick_n = kick_cnt + KW'(1);
          if (tgt_c == 7'd0) begin
            state_n = ST_OFF;
            duty_n  = 7'd0;
          end else if (kick_cnt == KW'(KICK_PERIODS - 1)) begin
            state_n = ST_RUN;
            ramp_n  = '0;
          end
        end
        ST_RUN: begin
          if (tgt_c == 7'd0) begin
            state_n = ST_OFF;
            duty_n  = 7'd0;
          end
`ifdef FAN_STALL_DET_EN
          // A tach edge in the same cycle proves rotation and vetoes a stall
          else if (!tach_edge_c && stall_cnt == SW'(STALL_PERIODS - 1)) begin
            state_n = ST_KICK;
            duty_n  = DUTY_MAX;
            kick_n  = '0;
            stall_n = 1'b1;
          end
`endif
          else begin
            ramp_n = ramp_cnt + RW'(1);
            if (ramp_cnt == RW'(RAMP_PERIODS - 1)) begin
              ramp_n = '0;
              if (duty_eff < tgt_c)      duty_n = duty_eff + 7'd1;
              else if (duty_eff > tgt_c) duty_n = duty_eff - 7'd1;
            end
`ifdef FAN_STALL_DET_EN
            if (!tach_edge_c) stall_cnt_n = stall_cnt + SW'(1);
`endif
          end
        end
        default: begin
          state_n = ST_OFF;
          duty_n  = 7'd0;
        end
      endcase
    end
`ifdef FAN_STALL_DET_EN
    // Stall counting only runs while in RUN
    if (state_n != ST_RUN) stall_cnt_n = '0;
`endif
  end

endmodule

// File: tb/tb_fan_pwm_gen.sv
// tb_fan_pwm_gen: scoreboard bench for fan_pwm_gen with short sim parameters.
// Each stimulus task pushes the expected per-period state, applied duty and
// stall flag; the period runner pops one entry per PWM period and also checks
// the number of high pwm_out cycles in that period against duty*2.
module tb_fan_pwm_gen;

  localparam int unsigned P = 200;

  localparam logic [1:0] S_OFF  = 2'b00;
  localparam logic [1:0] S_KICK = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;

  typedef struct packed {
    logic [1:0] st;
    logic [6:0] duty;
    logic       stall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] duty_in = 7'd0;
  logic       fan_tach = 1'b0;
  logic       pwm_out;
  logic [6:0] duty_eff;
  logic [1:0] fan_state;
  logic       fan_stall;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   tach_en = 1'b1;

  fan_pwm_gen #(
    .PWM_PERIOD   (P),
    .KICK_PERIODS (3),
    .RAMP_PERIODS (2),
    .STALL_PERIODS(5)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .duty_in  (duty_in),
    .fan_tach (fan_tach),
    .pwm_out  (pwm_out),
    .duty_eff (duty_eff),
    .fan_state(fan_state),
    .fan_stall(fan_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_n(input int n, input logic [1:0] st, input logic [6:0] d, input logic s);
    exp_t e;
    e.st    = st;
    e.duty  = d;
    e.stall = s;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Runs n periods from a period start; optionally changes duty_in at cnt==chg_at
  // during the first period. A tach pulse is generated mid-period when enabled.
  task automatic run_periods(input int n, input int chg_at, input logic [6:0] chg_val);
    exp_t e;
    int   highs;
    for (int p = 0; p < n; p++) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got 0 entries want 1");
        return;
      end
      e = sb.pop_front();
      total++;
      if (fan_state !== e.st) begin
        bad++;
        $display("FAIL fan_state: got %b want %b (t=%0t)", fan_state, e.st, $time);
      end
      total++;
      if (duty_eff !== e.duty) begin
        bad++;
        $display("FAIL duty_eff: got %0d want %0d (t=%0t)", duty_eff, e.duty, $time);
      end
      total++;
      if (fan_stall !== e.stall) begin
        bad++;
        $display("FAIL fan_stall: got %b want %b (t=%0t)", fan_stall, e.stall, $time);
      end
      highs = 0;
      for (int i = 0; i < int'(P); i++) begin
        @(posedge clk);
        #1;
        if (pwm_out === 1'b1) highs++;
        if (p == 0 && chg_at >= 0 && i + 1 == chg_at) duty_in = chg_val;
        fan_tach = tach_en && (i >= 49) && (i < 149);
      end
      total++;
      if (highs !== int'(e.duty) * 2) begin
        bad++;
        $display("FAIL pwm_high: got %0d want %0d (t=%0t)", highs, int'(e.duty) * 2, $time);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    duty_in = 7'd50;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (pwm_out !== 1'b0) begin bad++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
    total++;
    if (duty_eff !== 7'd0) begin bad++; $display("FAIL rst_duty: got %0d want 0", duty_eff); end
    total++;
    if (fan_state !== S_OFF) begin bad++; $display("FAIL rst_state: got %b want 00", fan_state); end
    total++;
    if (fan_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", fan_stall); end
    rst = 1'b0;
    duty_in = 7'd0;
    push_n(3, S_OFF, 7'd0, 1'b0);
    run_periods(3, -1, 7'd0);
  endtask

  task automatic test_kick_ramp();
    duty_in = 7'd40;
    push_n(1, S_OFF, 7'd0, 1'b0);
    push_n(3, S_KICK, 7'd100, 1'b0);
    for (int d = 100; d > 40; d--) push_n(2, S_RUN, 7'(d), 1'b0);
    push_n(3, S_RUN, 7'd40, 1'b0);
    run_periods(127, -1, 7'd0);
  endtask

  // Ramp counter is mid-phase here, so the first step lands at the first period end
  task automatic test_clamp_mid_period();
    push_n(1, S_RUN, 7'd40, 1'b0);
    for (int d = 41; d < 100; d++) push_n(2, S_RUN, 7'(d), 1'b0);
    push_n(3, S_RUN, 7'd100, 1'b0);
    run_periods(122, 50, 7'd120);
  endtask

  task automatic test_stop();
    duty_in = 7'd0;
    push_n(1, S_RUN, 7'd100, 1'b0);
    push_n(2, S_OFF, 7'd0, 1'b0);
    run_periods(3, -1, 7'd0);
    duty_in = 7'd30;
    push_n(1, S_OFF, 7'd0, 1'b0);
    push_n(1, S_KICK, 7'd100, 1'b0);
    run_periods(2, -1, 7'd0);
    duty_in = 7'd0;
    push_n(1, S_KICK, 7'd100, 1'b0);
    push_n(2, S_OFF, 7'd0, 1'b0);
    run_periods(3, -1, 7'd0);
  endtask

  task automatic test_mid_reset();
    duty_in = 7'd60;
    push_n(1, S_OFF, 7'd0, 1'b0);
    push_n(1, S_KICK, 7'd100, 1'b0);
    run_periods(2, -1, 7'd0);
    repeat (77) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (pwm_out !== 1'b0) begin bad++; $display("FAIL midrst_pwm: got %b want 0", pwm_out); end
    total++;
    if (fan_state !== S_OFF) begin bad++; $display("FAIL midrst_state: got %b want 00", fan_state); end
    total++;
    if (duty_eff !== 7'd0) begin bad++; $display("FAIL midrst_duty: got %0d want 0", duty_eff); end
    // Period alignment after reset proves the counter restarted at 0
    push_n(1, S_OFF, 7'd0, 1'b0);
    push_n(2, S_KICK, 7'd100, 1'b0);
    run_periods(3, -1, 7'd0);
    duty_in = 7'd0;
    push_n(1, S_KICK, 7'd100, 1'b0);
    push_n(1, S_OFF, 7'd0, 1'b0);
    run_periods(2, -1, 7'd0);
  endtask

  task automatic test_stall();
    do_reset();
    tach_en = 1'b1;
    duty_in = 7'd100;
    push_n(1, S_OFF, 7'd0, 1'b0);
    push_n(3, S_KICK, 7'd100, 1'b0);
    push_n(2, S_RUN, 7'd100, 1'b0);
    run_periods(6, -1, 7'd0);
    tach_en = 1'b0;
`ifdef FAN_STALL_DET_EN
    push_n(4, S_RUN, 7'd100, 1'b0);
    push_n(1, S_KICK, 7'd100, 1'b1);
    run_periods(5, -1, 7'd0);
    fan_tach = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (fan_stall === 1'b0) break;
    end
    total++;
    if (fan_stall !== 1'b0) begin bad++; $display("FAIL stall_clear: got %b want 0", fan_stall); end
    fan_tach = 1'b0;
`else
    push_n(5, S_RUN, 7'd100, 1'b0);
    run_periods(5, -1, 7'd0);
`endif
    tach_en = 1'b1;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_kick_ramp();
    test_clamp_mid_period();
    test_stop();
    test_mid_reset();
    test_stall();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
